sobel_filter: RTL

Streaming 3x3 Sobel edge-detection stage sitting directly downstream of the zero-padding stage in the Sobel pipeline. Pops the padded (IMG_WIDTH+2)x(IMG_HEIGHT+2) 8-bit pixel stream from a FIFO and keeps the last two padded rows plus two pixels in a shift register. Computes an 8-bit gradient magnitude for every interior window and pushes exactly IMG_WIDTH*IMG_HEIGHT results per frame to the output FIFO.

---
 rtl/sobel_pkg.sv | 31 +++
 rtl/sobel_kernel.sv | 41 ++++
 rtl/sobel_filter.sv | 99 +++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared widths, defaults, kernel coefficients and helpers for the Sobel pipeline.
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 720;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int GRAD_W         = 11;
  localparam int MAG_W          = 12;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;
  // win[r][c]: r=0 is the oldest (top) row, c=0 the leftmost column.
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  localparam mag_t SAT_LIMIT = 12'd255;

  localparam grad_t KX [3][3] = '{'{-11'sd1, 11'sd0, 11'sd1},
                                  '{-11'sd2, 11'sd0, 11'sd2},
                                  '{-11'sd1, 11'sd0, 11'sd1}};
  localparam grad_t KY [3][3] = '{'{-11'sd1, -11'sd2, -11'sd1},
                                  '{ 11'sd0,  11'sd0,  11'sd0},
                                  '{ 11'sd1,  11'sd2,  11'sd1}};

  function automatic mag_t abs_grad(input grad_t g);
    grad_t a;
    a = g[GRAD_W-1] ? -g : g;
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude with saturation or optional threshold.
// Build option: SOBEL_BINARIZE_EN selects a 0/255 output against THRESHOLD.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  logic [2:0][2:0][7:0] win,
  output logic [7:0]           result
);

`ifdef SOBEL_BINARIZE_EN
  localparam bit BINARIZE = 1'b1;
`else
  localparam bit BINARIZE = 1'b0;
`endif

  localparam mag_t THR_M = MAG_W'(THRESHOLD);

  grad_t gx;
  grad_t gy;
  mag_t  mag;

  always_comb begin
    gx = '0;
    gy = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx = gx + KX[r][c] * grad_t'({3'b000, win[r][c]});
        gy = gy + KY[r][c] * grad_t'({3'b000, win[r][c]});
      end
    end
    mag = (abs_grad(gx) + abs_grad(gy)) >> 1;
    if (BINARIZE) begin
      result = (mag >= THR_M) ? 8'hFF : 8'h00;
    end else begin
      result = (mag > SAT_LIMIT) ? 8'hFF : mag[7:0];
    end
  end

endmodule

// File: rtl/sobel_filter.sv
// Streaming Sobel stage: pops padded pixels, keeps two rows plus two pixels of
// history and pushes one result per interior window. Option: SOBEL_BINARIZE_EN.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int THRESHOLD  = 128
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  input  logic       out_full
);

  localparam int PW     = IMG_WIDTH + 2;
  localparam int PH     = IMG_HEIGHT + 2;
  localparam int SR_LEN = 2 * PW + 2;
  localparam int CW     = $clog2(PW);
  localparam int RW     = $clog2(PH);

  localparam logic [CW-1:0] COL_LAST  = CW'(PW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(PH - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pix_t          sr_q [SR_LEN];
  pix_t          sr_d [SR_LEN];

  logic       rd;
  logic       valid;
  win_t       win;
  logic [7:0] result;

  // Reads stall on a full output FIFO even when no result is due.
  assign rd        = !in_empty && !out_full;
  assign valid     = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign in_rd_en  = rd;
  assign out_wr_en = rd && valid;
  assign out_din   = out_wr_en ? result : 8'h00;

  always_comb begin
    win[0][0] = sr_q[2*PW+1];
    win[0][1] = sr_q[2*PW];
    win[0][2] = sr_q[2*PW-1];
    win[1][0] = sr_q[PW+1];
    win[1][1] = sr_q[PW];
    win[1][2] = sr_q[PW-1];
    win[2][0] = sr_q[1];
    win[2][1] = sr_q[0];
    win[2][2] = in_dout;
  end

  sobel_kernel #(
    .THRESHOLD(THRESHOLD)
  ) u_kernel (
    .win   (win),
    .result(result)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sr_d  = sr_q;
    if (rd) begin
      for (int i = SR_LEN - 1; i > 0; i--) begin
        sr_d[i] = sr_q[i-1];
      end
      sr_d[0] = in_dout;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i < SR_LEN; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sr_q  <= sr_d;
    end
  end

endmodule
